// File: rtl/ccff_loader_pkg.sv
// Shared configuration-chain definitions: loader FSM states, default chain
// length of the generated fabric, and the stream byte width.
package fpga_cfg_pkg;

  localparam int CHAIN_LEN_DEFAULT = 1024;
  localparam int BYTE_W            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_HIGH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ccff_loader_if.sv
// Byte stream, readback stream, run control and configuration-chain pins of
// the bitstream loader. The loader uses the slave view, the host the master view.
interface ccff_loader_if;
  import fpga_cfg_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              prog_clk;
  logic              ccff_head;
  logic              ccff_tail;
  logic [BYTE_W-1:0] rb_data;
  logic              rb_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, s_data, s_valid, ccff_tail,
    input  s_ready, prog_clk, ccff_head, rb_data, rb_valid, busy, done
  );

  modport slave (
    input  start, s_data, s_valid, ccff_tail,
    output s_ready, prog_clk, ccff_head, rb_data, rb_valid, busy, done
  );

endinterface

// File: rtl/ccff_clkgen.sv
// prog_clk generator: a DIV-cycle phase counter toggles a registered prog_clk
// level while enabled. rise_o/fall_o flag the clk edge at which prog_clk will
// go high/low. Disabling returns prog_clk and the phase to zero.
module ccff_clkgen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic prog_clk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pclk_q, pclk_d;
  logic          tc;

  // Phase counter next state; terminal count toggles the prog_clk level.
  always_comb begin
    tc     = en_i && (cnt_q == LAST);
    cnt_d  = cnt_q;
    pclk_d = pclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      pclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      pclk_d = ~pclk_q;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end
  end

  // Phase and level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pclk_q <= pclk_d;
    end
  end

  assign prog_clk_o = pclk_q;
  assign rise_o     = tc && !pclk_q;
  assign fall_o     = tc && pclk_q;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain bitstream loader: serializes stream bytes MSB-first onto
// ccff_head under a generated prog_clk, and repacks the bits leaving ccff_tail
// into readback bytes. Runs exactly CHAIN_LEN bits per start pulse.
module ccff_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int DIV       = 4
) (
  input logic          clk,
  input logic          reset,
  ccff_loader_if.slave bus
);

  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int IW  = $clog2(BYTE_W);
  // Left shift that MSB-aligns a short final readback byte.
  localparam int PAD = (BYTE_W - (CHAIN_LEN % BYTE_W)) % BYTE_W;

  state_e            state_q, state_d;
  logic [BCW-1:0]    bitcnt_q;
  logic [IW-1:0]     bidx_q;
  logic              head_q;
  logic [BYTE_W-2:0] sh_q;
  logic [BYTE_W-2:0] rb_sh_q;
  logic [BYTE_W-1:0] rb_data_q;
  logic              rb_valid_q;

  logic              clk_en, pclk, rise, fall;
  logic              accept, capture, advance, is_last, rb_emit;
  logic [BYTE_W-1:0] rb_word;

  ccff_clkgen #(.DIV(DIV)) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .en_i       (clk_en),
    .prog_clk_o (pclk),
    .rise_o     (rise),
    .fall_o     (fall)
  );

  assign is_last = (bitcnt_q == BCW'(CHAIN_LEN - 1));
  assign accept  = (state_q == ST_FETCH) && bus.s_valid;
  assign capture = (state_q == ST_SETUP) && rise;
  assign advance = (state_q == ST_HIGH) && fall;
  // ccff_tail is sampled on the edge that raises prog_clk, i.e. before the fabric shifts.
  assign rb_word = {rb_sh_q, bus.ccff_tail};
  assign rb_emit = capture && ((bidx_q == '0) || is_last);

  // Run sequencing and prog_clk enable.
  always_comb begin
    state_d = state_q;
    clk_en  = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_FETCH;
      ST_FETCH: if (bus.s_valid) state_d = ST_SETUP;
      ST_SETUP: begin
        clk_en = 1'b1;
        if (rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        clk_en = 1'b1;
        if (fall) begin
          if (is_last)              state_d = ST_DONE;
          else if (bidx_q == '0)    state_d = ST_FETCH;
          else                      state_d = ST_SETUP;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, counters, head bit and readback output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      bidx_q     <= '0;
      head_q     <= 1'b0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rb_valid_q <= rb_emit;
      if (rb_emit) rb_data_q <= is_last ? (rb_word << PAD) : rb_word;
      if ((state_q == ST_IDLE) && bus.start) bitcnt_q <= '0;
      if (accept) begin
        bidx_q <= IW'(BYTE_W - 1);
        head_q <= bus.s_data[BYTE_W-1];
      end
      if (advance) begin
        bitcnt_q <= bitcnt_q + BCW'(1);
        bidx_q   <= bidx_q - IW'(1);
        if (state_d == ST_SETUP) head_q <= sh_q[BYTE_W-2];
      end
    end
  end

  // Outgoing byte remainder and incoming readback bits.
  always_ff @(posedge clk) begin
    if (accept)       sh_q <= bus.s_data[BYTE_W-2:0];
    else if (advance) sh_q <= {sh_q[BYTE_W-3:0], 1'b0};
    if (capture) rb_sh_q <= rb_word[BYTE_W-2:0];
  end

  assign bus.s_ready   = (state_q == ST_FETCH);
  assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.prog_clk  = pclk;
  assign bus.ccff_head = head_q;
  assign bus.rb_data   = rb_data_q;
  assign bus.rb_valid  = rb_valid_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (16-bit chain / DIV=2 and 12-bit chain /
// DIV=1), each looped back through a shift-register chain stub.
module tb_ccff_loader;
  import fpga_cfg_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       start_d = 1'b0;
  logic [7:0] data_d = 8'h00;
  logic       valid_d = 1'b0;

  ccff_loader_if ifa();
  ccff_loader_if ifb();

  logic [15:0] chain_a = 16'hDEAD;
  logic [11:0] chain_b = 12'hABC;

  assign ifa.start     = start_d & ~sel;
  assign ifa.s_data    = data_d;
  assign ifa.s_valid   = valid_d & ~sel;
  assign ifa.ccff_tail = chain_a[15];
  assign ifb.start     = start_d & sel;
  assign ifb.s_data    = data_d;
  assign ifb.s_valid   = valid_d & sel;
  assign ifb.ccff_tail = chain_b[11];

  always @(posedge ifa.prog_clk) chain_a <= {chain_a[14:0], ifa.ccff_head};
  always @(posedge ifb.prog_clk) chain_b <= {chain_b[10:0], ifb.ccff_head};

  ccff_loader #(.CHAIN_LEN(16), .DIV(2)) u_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  ccff_loader #(.CHAIN_LEN(12), .DIV(1)) u_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  logic       pclk_m, head_m, ready_m, rbv_m, busy_m, done_m;
  logic [7:0] rbd_m;
  assign pclk_m  = sel ? ifb.prog_clk  : ifa.prog_clk;
  assign head_m  = sel ? ifb.ccff_head : ifa.ccff_head;
  assign ready_m = sel ? ifb.s_ready   : ifa.s_ready;
  assign rbv_m   = sel ? ifb.rb_valid  : ifa.rb_valid;
  assign busy_m  = sel ? ifb.busy      : ifa.busy;
  assign done_m  = sel ? ifb.done      : ifa.done;
  assign rbd_m   = sel ? ifb.rb_data   : ifa.rb_data;

  // Monitors
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         hq[$];
  logic [7:0] rbq[$];
  int   n_acc = 0, n_done = 0, n_hi = 0, n_viol = 0, since = 0;
  logic head_prev = 1'b0, pclk_prev = 1'b0;

  always @(posedge pclk_m) hq.push_back(head_m);

  always @(negedge clk) begin
    if (valid_d && ready_m === 1'b1) n_acc++;
    if (done_m === 1'b1) n_done++;
    if (rbv_m === 1'b1) rbq.push_back(rbd_m);
    if (pclk_m === 1'b1) n_hi++;
    if (head_m !== head_prev) begin
      if (pclk_m === 1'b1) n_viol++;
      since = 0;
    end else begin
      since++;
    end
    if (pclk_m === 1'b1 && pclk_prev === 1'b0 && since < (sel ? 1 : 2)) n_viol++;
    head_prev = head_m;
    pclk_prev = pclk_m;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One programming run of two bytes; expectations supplied by caller.
  task automatic do_run(input bit s, input logic [7:0] b0, input logic [7:0] b1,
                        input int starve, input bit xstart, input bit chk_len,
                        input bit rb_ok, input logic [15:0] exp_head,
                        input logic [15:0] exp_rb, input string tag);
    int cl, dv, h0, r0, a0, d0, hi0, v0, t0, t1, guard, bad;
    bit acc, seen;
    logic busy_at_done;
    logic [15:0] got;
    cl = s ? 12 : 16;
    dv = s ? 1 : 2;
    h0 = hq.size(); r0 = rbq.size(); a0 = n_acc; d0 = n_done; hi0 = n_hi; v0 = n_viol;
    sel = s;
    start_d = 1'b1;
    t0 = cyc;
    t1 = t0;
    busy_at_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1 && starve > 0) begin
        valid_d = 1'b0;
        guard = 0;
        @(negedge clk);
        while (ready_m !== 1'b1 && guard < 500) begin
          @(negedge clk);
          guard++;
        end
        bad = 0;
        for (int k = 0; k < starve; k++) begin
          if (pclk_m !== 1'b0 || busy_m !== 1'b1 || ready_m !== 1'b1) bad++;
          @(negedge clk);
        end
        chk({tag, " starve_window"}, bad, 0);
        @(posedge clk); #1;
      end
      valid_d = 1'b1;
      data_d  = (i == 0) ? b0 : b1;
      if (i == 1 && xstart) start_d = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard <= 500) begin
        @(negedge clk);
        acc = (ready_m === 1'b1);
        @(posedge clk); #1;
        start_d = 1'b0;
        guard++;
      end
      chk({tag, " byte_accept"}, acc, 1);
    end
    data_d = 8'h00;
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (done_m === 1'b1) begin
        seen = 1'b1;
        t1 = cyc;
        busy_at_done = busy_m;
      end
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " busy_at_done"}, busy_at_done, 0);
    repeat (8) @(negedge clk);
    if (chk_len) chk({tag, " run_len"}, t1 - t0 + 1, 1 + cl * 2 * dv + 2 + 1);
    chk({tag, " rises"}, hq.size() - h0, cl);
    got = '0;
    for (int j = 0; j < cl; j++)
      if (h0 + j < hq.size()) got[15 - j] = hq[h0 + j];
    chk({tag, " head_bits"}, got, exp_head);
    chk({tag, " bytes_accepted"}, n_acc - a0, 2);
    chk({tag, " done_pulses"}, n_done - d0, 1);
    chk({tag, " prog_clk_high_cycles"}, n_hi - hi0, cl * dv);
    chk({tag, " head_timing"}, n_viol - v0, 0);
    chk({tag, " busy_after"}, busy_m, 0);
    if (rb_ok) begin
      chk({tag, " rb_count"}, rbq.size() - r0, 2);
      if (rbq.size() >= r0 + 2) chk({tag, " rb_bytes"}, {rbq[r0], rbq[r0 + 1]}, exp_rb);
    end
    @(posedge clk); #1;
    valid_d = 1'b0;
  endtask

  typedef struct {
    bit          s;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          starve;
    bit          xs;
    bit          chk_len;
    logic [15:0] exp_head;
    logic [15:0] exp_rb;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] mdl[2];
  bit          known[2];

  initial begin
    int guard, h0;
    bit s, xs;
    int starve, cl;
    logic [7:0] b0, b1;
    logic [15:0] eh;

    tbl[0] = '{1'b0, 8'hA5, 8'h3C, 0,  1'b0, 1'b1, 16'hA53C, 16'hDEAD};
    tbl[1] = '{1'b0, 8'h12, 8'h34, 0,  1'b0, 1'b1, 16'h1234, 16'hA53C};
    tbl[2] = '{1'b0, 8'h5A, 8'hC3, 50, 1'b0, 1'b0, 16'h5AC3, 16'h1234};
    tbl[3] = '{1'b0, 8'h0F, 8'hF0, 0,  1'b1, 1'b1, 16'h0FF0, 16'h5AC3};
    tbl[4] = '{1'b1, 8'hFF, 8'hF0, 0,  1'b0, 1'b1, 16'hFFF0, 16'hABC0};
    tbl[5] = '{1'b1, 8'h81, 8'h7E, 0,  1'b0, 1'b1, 16'h8170, 16'hFFF0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl_a", {ifa.prog_clk, ifa.ccff_head, ifa.s_ready, ifa.rb_valid, ifa.busy, ifa.done}, 0);
    chk("rst_rbdata_a", ifa.rb_data, 0);
    chk("rst_ctrl_b", {ifb.prog_clk, ifb.ccff_head, ifb.s_ready, ifb.rb_valid, ifb.busy, ifb.done}, 0);
    chk("rst_rbdata_b", ifb.rb_data, 0);
    chk("rst_state_a", u_a.state_q, ST_IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      do_run(tbl[i].s, tbl[i].b0, tbl[i].b1, tbl[i].starve, tbl[i].xs, tbl[i].chk_len,
             1'b1, tbl[i].exp_head, tbl[i].exp_rb, $sformatf("vec%0d", i));
    mdl[0] = 16'h0FF0; known[0] = 1'b1;
    mdl[1] = 16'h8170; known[1] = 1'b1;

    // Reset while prog_clk is high
    sel = 1'b0;
    h0 = hq.size();
    start_d = 1'b1; valid_d = 1'b1; data_d = 8'h99;
    @(posedge clk); #1;
    start_d = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(pclk_m === 1'b1 && hq.size() - h0 >= 5) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("midrst_reached_high", pclk_m, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_prog_clk", pclk_m, 0);
    chk("midrst_busy", busy_m, 0);
    chk("midrst_state", u_a.state_q, ST_IDLE);
    reset = 1'b0; valid_d = 1'b0;
    @(posedge clk); #1;
    known[0] = 1'b0;
    do_run(1'b0, 8'hC6, 8'h6C, 0, 1'b0, 1'b1, 1'b0, 16'hC66C, 16'h0000, "after_rst");
    mdl[0] = 16'hC66C; known[0] = 1'b1;

    // Random runs against the chain-content model
    for (int r = 0; r < 8; r++) begin
      s      = 1'($urandom_range(0, 1));
      b0     = 8'($urandom);
      b1     = 8'($urandom);
      starve = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 20)) : 0;
      xs     = 1'($urandom_range(0, 1));
      cl     = s ? 12 : 16;
      eh     = {b0, b1} & (16'hFFFF << (16 - cl));
      do_run(s, b0, b1, starve, xs, starve == 0, known[s], eh, mdl[s], $sformatf("rnd%0d", r));
      mdl[s]   = eh;
      known[s] = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Bitstream programmer for the fabric's configuration chain: takes configuration bytes over a valid/ready stream, serializes them MSB-first onto `ccff_head` and generates `prog_clk` so the fabric shifts them in. It simultaneously captures the bits falling out of `ccff_tail` and repacks them as readback bytes for verification. It sits on the driving side of the `prog_clk`/`ccff_head`/`ccff_tail` pins, either in a host-side test harness or an on-chip boot controller.

## Interface
- `CHAIN_LEN`, default 1024: total configuration bits shifted per programming run (≥1).
- `DIV`, default 4: `prog_clk` half-period in `clk` cycles (≥1).
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a run; ignored while `busy`.
- `s_data` input 8: configuration byte; its MSB is shifted first.
- `s_valid` input 1: `s_data` valid.
- `s_ready` output 1: byte accepted on a cycle where `s_valid & s_ready`.
- `prog_clk` output 1: configuration shift clock; registered, glitch-free.
- `ccff_head` output 1: serial configuration data into the chain.
- `ccff_tail` input 1: serial data out of the chain's last flop.
- `rb_data` output 8: readback byte; the first captured bit is in the MSB.
- `rb_valid` output 1: one-cycle pulse qualifying `rb_data`. No backpressure.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse when a run completes.

## Operation
- Reset values: `prog_clk`=0, `ccff_head`=0, `s_ready`=0, `rb_data`=0, `rb_valid`=0, `busy`=0, `done`=0. The bit counter is cleared and the state is IDLE.
- States:
  - IDLE: on `start`, go to FETCH. `busy` becomes 1 on the next cycle.
  - FETCH: `s_ready`=1 until a byte is accepted. Then load the shift register, set the byte bit index to 7, and go to SETUP.
  - SETUP: drive `ccff_head` with the current bit. Hold `prog_clk` low for DIV cycles, then go to HIGH.
  - HIGH: on entry, `prog_clk` rises and `ccff_tail` is sampled into the readback shifter in the same `clk` cycle; this is the value before the fabric shifts. Hold for DIV cycles, then drop `prog_clk` and increment the bit counter.
  - After HIGH:
    - if the bit counter reaches CHAIN_LEN, go to DONE;
    - else if the byte is exhausted, go to FETCH;
    - else go to SETUP with the next bit.
  - DONE: pulse `done` for one cycle, clear `busy`, return to IDLE.
- Partial last byte: when CHAIN_LEN mod 8 ≠ 0, only the top (CHAIN_LEN mod 8) bits of the final byte are shifted. The rest are discarded, and no further bytes are requested.
- Readback: after every 8th captured bit, pulse `rb_valid`. On the final bit of a partial byte, pulse `rb_valid` with the captured bits MSB-aligned and the LSBs zero.
- Starvation: if `s_valid`=0 in FETCH, `prog_clk` stays low indefinitely and the fabric holds state; no error is raised.
- `s_ready` is asserted only in FETCH, so exactly ceil(CHAIN_LEN/8) bytes are consumed per run.
- `start` while `busy` is ignored. `start` and `reset` in the same cycle: reset wins.
- Reset mid-run: the next cycle shows reset values, including `prog_clk`=0. The partially shifted chain is left as-is; software re-runs.

## Timing
- From a `start` pulse in cycle 0: FETCH is entered in cycle 1 and `s_ready`=1 from cycle 1.
- Accepting a byte in cycle n:
  - SETUP starts in n+1 with `ccff_head` valid;
  - `prog_clk` rises in n+1+DIV;
  - `prog_clk` falls in n+1+2·DIV.
- `ccff_head` changes only while `prog_clk`=0, and at least DIV `clk` cycles before a rising edge.
- Per bit: 2·DIV cycles. Between bytes, FETCH adds one extra cycle when `s_valid` is already high.
- Minimum run length: 1 + CHAIN_LEN·2·DIV + ceil(CHAIN_LEN/8) + 1 cycles.
- `rb_valid`/`rb_data` are registered. They appear the cycle after the 8th capture.
- `done` pulses the cycle after the final falling edge of `prog_clk`. `busy` is 0 in that same cycle.

## Structure
- Shared package `fpga_cfg_pkg` holds:
  - the state enum (IDLE, FETCH, SETUP, HIGH, DONE);
  - the default CHAIN_LEN constant, matching the fabric's generated chain length;
  - the byte width constant.
- One sub-module, `ccff_clkgen`: a DIV-cycle phase counter that produces the registered `prog_clk` level and a `rise` strobe. It has `clk`/`reset` ports and an enable.
- The FSM, the shift and readback registers, and the bit counter of width $clog2(CHAIN_LEN+1) live in `ccff_loader`.

## Test plan
- CHAIN_LEN=16, DIV=2, bytes 0xA5, 0x3C, `s_valid` always high:
  - `ccff_head` sequence at `prog_clk` rises is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0;
  - exactly 16 rises, 2 bytes accepted, `done` at cycle 1+64+2+1.
- Loopback with a 16-flop chain model fed by `ccff_head` and pre-loaded with 0xDEAD:
  - `rb_data` pulses 0xDE then 0xAD;
  - a second run returns the first run's bytes.
- CHAIN_LEN=12, bytes 0xFF, 0xF0:
  - 12 rises; the second byte's low nibble is never shifted;
  - the second `rb_valid` has LSBs [3:0]=0;
  - `s_ready` is never asserted a third time.
- Starvation: drop `s_valid` for 50 cycles before the second byte:
  - `prog_clk` stays 0 for that window and `busy` stays 1;
  - the run completes correctly afterwards.
- Assert `reset` while in HIGH: the next cycle shows `prog_clk`=0, `busy`=0, and state IDLE. A new `start` then runs a full CHAIN_LEN.
- `start` pulsed during a run has no effect (same rise count and single `done`). DIV=1 yields `prog_clk` toggling every cycle.
